// File: rtl/score_bcd_converter_if.sv
// Score-to-display bundle: binary score in, packed BCD digits, blanking mask and status out.
// master drives the score; slave is the converter.
interface score_bcd_converter_if #(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 5
);
  logic [BIN_W-1:0]    score;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   digits_lit;
  logic                busy;
  logic                done;
  logic                clamped;

  modport master (
    output score,
    input  bcd, digits_lit, busy, done, clamped
  );

  modport slave (
    input  score,
    output bcd, digits_lit, busy, done, clamped
  );
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble converter: clamps the score, shifts one bit per clock into a
// BCD scratch register, then publishes digits and a leading-zero blanking mask together.
module score_bcd_converter #(
  parameter int BIN_W     = 17,
  parameter int DIGITS    = 5,
  parameter int MAX_VALUE = 99999
) (
  input  logic                 clk,
  input  logic                 reset,
  score_bcd_converter_if.slave bus
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VALUE);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [BIN_W-1:0]   work_bin;
  logic [SCR_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   last_val;
  logic               clamped_next;
  logic [SCR_W-1:0]   bcd_r;
  logic [DIGITS-1:0]  lit_r;
  logic               busy_r;
  logic               done_r;
  logic               clamped_r;

  logic [SCR_W-1:0]   scr_adj;
  logic [SCR_W-1:0]   scr_shift;
  logic [BIN_W-1:0]   bin_shift;

  // Add 3 to every nibble >= 5 so the following left shift carries correctly into the next digit.
  function automatic logic [SCR_W-1:0] add3_all(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digit i is lit when it or any more-significant digit is nonzero; the ones digit always shows.
  function automatic logic [DIGITS-1:0] lit_mask(input logic [SCR_W-1:0] s);
    logic [DIGITS-1:0] r;
    logic              any_nz;
    r      = '0;
    any_nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      any_nz = any_nz | (s[4*i +: 4] != 4'd0);
      r[i]   = any_nz;
    end
    r[0] = 1'b1;
    return r;
  endfunction

  always_comb begin
    scr_adj   = add3_all(scratch);
    scr_shift = {scr_adj[SCR_W-2:0], work_bin[BIN_W-1]};
    bin_shift = {work_bin[BIN_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_val     <= '0;
      clamped_next <= 1'b0;
      bcd_r        <= '0;
      lit_r        <= DIGITS'(1);
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      clamped_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        // Sample stage: only a changed score starts a conversion; changes during busy are caught here later.
        IDLE: begin
          if (bus.score != last_val) begin
            work_bin     <= (bus.score > MAX_BIN) ? MAX_BIN : bus.score;
            last_val     <= bus.score;
            scratch      <= '0;
            cnt          <= CNT_W'(BIN_W);
            clamped_next <= (bus.score > MAX_BIN);
            busy_r       <= 1'b1;
            state        <= SHIFT;
          end
        end
        // Shift stage: one binary bit enters the BCD scratch per clock.
        SHIFT: begin
          scratch  <= scr_shift;
          work_bin <= bin_shift;
          cnt      <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= DONE;
        end
        // Publish stage: all visible outputs change in one edge so the HUD never sees a partial value.
        DONE: begin
          bcd_r     <= scratch;
          lit_r     <= lit_mask(scratch);
          clamped_r <= clamped_next;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bcd        = bcd_r;
  assign bus.digits_lit = lit_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.clamped    = clamped_r;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: decimal reference model feeds a queue,
// a negedge monitor checks every done pulse plus held outputs and busy each cycle.
module tb_score_bcd_converter;

  localparam int BIN_W     = 17;
  localparam int DIGITS    = 5;
  localparam int MAX_VALUE = 99999;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  score_bcd_converter_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  score_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS), .MAX_VALUE(MAX_VALUE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  lit;
    logic        clamped;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          m_free = 0;
  logic [16:0] m_last = '0;
  logic        rst_edge = 1'b0;

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_lit(input int v);
    logic [4:0] r;
    int p;
    r = 5'b00001;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      r[i] = (v >= p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  // Reference model: decides sample edges from the score/last-value rule and the 19-edge turnaround.
  initial begin
    exp_t e;
    int v;
    forever begin
      @(posedge clk);
      cyc++;
      rst_edge = reset;
      if (reset) begin
        m_last = '0;
        q.delete();
        m_free = cyc + 1;
      end else if (cyc >= m_free && bus.score != m_last) begin
        v = (int'(bus.score) > MAX_VALUE) ? MAX_VALUE : int'(bus.score);
        e.bcd     = ref_bcd(v);
        e.lit     = ref_lit(v);
        e.clamped = (int'(bus.score) > MAX_VALUE);
        e.due     = cyc + 18;
        q.push_back(e);
        m_last = bus.score;
        m_free = cyc + 19;
      end
    end
  end

  // Monitor: pops on done, and checks displayed values hold steady between updates.
  initial begin
    exp_t e;
    logic [19:0] d_bcd;
    logic [4:0]  d_lit;
    logic        d_clamp;
    d_bcd = '0; d_lit = 5'b00001; d_clamp = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (rst_edge) begin
          d_bcd = '0; d_lit = 5'b00001; d_clamp = 1'b0;
        end
        if (bus.done === 1'b1) begin
          if (q.size() == 0) begin
            chk("spurious_done", 32'(bus.done), 32'd0);
          end else begin
            e = q.pop_front();
            chk("done_latency", 32'(cyc), 32'(e.due));
            d_bcd = e.bcd; d_lit = e.lit; d_clamp = e.clamped;
          end
        end else begin
          chk("done_level", 32'(bus.done), 32'd0);
          if (q.size() > 0 && cyc >= q[0].due) begin
            chk("missing_done", 32'(bus.done), 32'd1);
            void'(q.pop_front());
          end
        end
        chk("bcd", 32'(bus.bcd), 32'(d_bcd));
        chk("digits_lit", 32'(bus.digits_lit), 32'(d_lit));
        chk("clamped", 32'(bus.clamped), 32'(d_clamp));
        chk("busy", 32'(bus.busy), 32'(cyc <= m_free - 2));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [16:0] rand_score();
    case ($urandom % 4)
      0:       return 17'($urandom_range(0, 9));
      1:       return 17'($urandom_range(0, 999));
      2:       return 17'($urandom_range(0, 99999));
      default: return 17'($urandom_range(99990, 131071));
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    bus.score = '0;
    tick(2);
    reset = 1'b0;
    tick(40);
    bus.score = 17'd12345;  tick(25);
    bus.score = 17'd100;    tick(22);
    bus.score = 17'd7;      tick(22);
    bus.score = 17'd131071; tick(22);
    bus.score = 17'd99999;  tick(22);
    bus.score = 17'd10;     tick(5);
    bus.score = 17'd500;    tick(45);
    bus.score = 17'd54321;  tick(9);
    reset = 1'b1;           tick(1);
    reset = 1'b0;           tick(25);
    bus.score = 17'd0;      tick(22);
    for (int s = 0; s < 150; s++) begin
      case ($urandom % 5)
        0: begin
          for (int k = 0; k < 30; k++) begin
            bus.score = rand_score();
            tick(1);
          end
        end
        1: begin
          bus.score = rand_score();
          tick($urandom_range(1, 12));
          reset = ($urandom % 3 == 0);
          tick(1);
          reset = 1'b0;
        end
        default: begin
          bus.score = rand_score();
          tick($urandom_range(1, 30));
        end
      endcase
    end
    tick(25);
    chk("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
